ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain loader that streams a bitstream into the serial configuration flip-flop chain threaded through a column of `grid_clb` tiles. Parallel words arrive over a valid/ready handshake. Each word is serialised LSB-first onto the chain head, with a per-bit shift enable driving the chain clock gating. Exactly CHAIN_LEN bits are shifted, then completion is reported; protocol violations are flagged. The block sits between the bitstream source (JTAG/SPI front end) and the fabric's `ccff_head`.

## Interface
- `WORD_W`, default 8: bitstream word width in bits (≥2).
- `CHAIN_LEN`, default 1024: number of configuration bits in the chain (≥1).
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: bit-counter width.

- `prog_clk` in 1: programming clock; the only clock.
- `pReset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a load; honoured only in IDLE.
- `abort` in 1: cancel an in-progress load.
- `cfg_data` in WORD_W: bitstream word; bit 0 is shifted first.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: word accepted on an edge where `cfg_valid && cfg_ready`.
- `ccff_head` out 1: serial data to the chain head.
- `ccff_shift_en` out 1: the chain shifts on a `prog_clk` edge where this is high.
- `busy` out 1: high in LOAD.
- `done` out 1: one-cycle pulse when the last chain bit has been shifted.
- `err_overrun` out 1: sticky error flag; cleared by `start` or `pReset`.

## Operation
- States are IDLE, LOAD and DONE.
- **IDLE**
  - `start` moves to LOAD and clears `bit_cnt`, the shift buffer and `err_overrun`.
  - `cfg_valid` in IDLE sets `err_overrun`. The word is not accepted (`cfg_ready` = 0).
- **LOAD**
  - The block holds a WORD_W-bit shift buffer plus a remaining-bits count `buf_cnt`.
  - `cfg_ready` = `buf_cnt==0 || buf_cnt==1`, and `words_accepted < ceil(CHAIN_LEN/WORD_W)`. This allows back-to-back words with no bubble.
  - On accept, the buffer is loaded with `cfg_data`. `buf_cnt` is set to `min(WORD_W, CHAIN_LEN − bits_committed)`; excess bits of the final word are discarded and never shifted.
  - Each cycle with `buf_cnt > 0`:
    - `ccff_head` = buffer bit 0 and `ccff_shift_en` = 1.
    - On the edge, the buffer shifts right, `buf_cnt` decrements and `bit_cnt` increments.
  - If the buffer is empty and no word arrives (source underflow), `ccff_shift_en` = 0 and the chain holds. This stall is not an error.
  - When `bit_cnt` reaches CHAIN_LEN, the next state is DONE.
- **DONE**: `done` = 1 for exactly one cycle, then the state returns to IDLE.
- `abort` in LOAD returns to IDLE on the next edge. On that edge the block shifts no bit, pulses no `done`, and leaves `err_overrun` unchanged. The partial chain contents are undefined.
- `abort` outside LOAD is ignored. If `abort` and `start` are both asserted in IDLE, `start` wins.
- `start` in LOAD or DONE is ignored.
- In LOAD, a `cfg_valid` arriving once all words have been accepted sets `err_overrun`; it does not stall the load.

## Timing
- Reset values:
  - state IDLE, counters 0, buffer 0.
  - `cfg_ready` 0, `ccff_head` 0, `ccff_shift_en` 0, `busy` 0, `done` 0, `err_overrun` 0.
- All outputs are registered, or are decoded only from registered state; there is no combinational path from inputs to outputs.
- `start` sampled at edge t gives `busy` = 1 from t+1 and `cfg_ready` = 1 from t+1.
- A word accepted at edge t drives its first bit with `ccff_shift_en` = 1 during cycle t+1.
- With no stalls, the load takes 1 + CHAIN_LEN cycles from the first accept to the last shift edge. `done` is high in the cycle after the last shift edge, and `busy` falls on the same edge that `done` rises.
- `pReset` mid-load returns the block to reset values on the next edge.

## Test plan
1. CHAIN_LEN=20, WORD_W=8. Start, then words 0xA5, 0x3C, 0xFF are held valid continuously.
   - Expect 20 consecutive `ccff_shift_en` cycles with serial bits 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
   - Expect 4 bits discarded and a one-cycle `done`.
   - Expect `cfg_ready` low after the third word.
2. Same configuration with `cfg_valid` dropped for 5 cycles after the first word.
   - Expect `ccff_shift_en` low for exactly 5 cycles and the same serial stream.
   - Expect `done` 5 cycles later than in scenario 1, with `err_overrun` = 0.
3. `cfg_valid` = 1 in IDLE → `err_overrun` = 1 and no accept. A subsequent `start` clears `err_overrun`.
4. `abort` after 9 shifted bits → IDLE next cycle, `ccff_shift_en` = 0, no `done`. A new `start` loads all 20 bits correctly.
5. `pReset` asserted mid-load → all outputs at reset values on the next edge.
6. A fourth valid word after three were accepted → `err_overrun` = 1, and `done` still occurs on schedule.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Streams a configuration bitstream into the serial CCFF chain of a grid_clb
// column. Words arrive on a valid/ready handshake. Each word is serialised
// LSB-first onto ccff_head, with ccff_shift_en marking the cycles in which the
// chain advances. Exactly CHAIN_LEN bits are shifted. Bits of the final word
// beyond CHAIN_LEN are dropped. A one-cycle done pulse marks completion, and
// words offered when none can be accepted raise a sticky err_overrun.
//
// Parameters
//   WORD_W     bitstream word width (>= 2)
//   CHAIN_LEN  number of configuration flip-flops in the chain (>= 1)
//   CNT_W      width of the shifted-bit counter
//
// Ports
//   prog_clk       programming clock (only clock)
//   pReset         synchronous active-high reset
//   start          begin a load (honoured in IDLE only)
//   abort          cancel a load in progress
//   cfg_data       bitstream word, bit 0 shifted first
//   cfg_valid      cfg_data is valid
//   cfg_ready      word accepted on an edge where cfg_valid && cfg_ready
//   ccff_head      serial data to the chain head
//   ccff_shift_en  chain shifts on an edge where this is high
//   busy           high while loading
//   done           one-cycle pulse after the last chain bit has shifted
//   err_overrun    sticky protocol-violation flag, cleared by start or pReset
//
// All outputs are decoded from registered state only. There is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err_overrun
);

  // Number of words needed to cover the whole chain (last one may be partial).
  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int WA_W   = $clog2(NWORDS + 1);
  localparam int BC_W   = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shbuf;           // serialiser, bit 0 is the next bit out
  logic [BC_W-1:0]   buf_cnt;         // valid bits still held in shbuf
  logic [CNT_W-1:0]  bit_cnt;         // bits already shifted into the chain
  logic [WA_W-1:0]   words_accepted;
  logic              err_q;

  logic              shifting;
  logic              all_accepted;
  logic              accept;
  logic              last_shift;
  logic [BC_W-1:0]   load_len;

  // Number of bits a freshly accepted word contributes: a full word, or just
  // the bits the chain still needs when the word is the final, partial one.
  function automatic logic [BC_W-1:0] clamp_len(input int remaining);
    if (remaining >= WORD_W) begin
      return BC_W'(WORD_W);
    end
    return BC_W'(remaining);
  endfunction

  always_comb begin
    shifting     = (state == LOAD) && (buf_cnt != '0);
    all_accepted = (words_accepted == WA_W'(NWORDS));
    // Ready while the last buffered bit is going out lets the next word land
    // on the same edge, so back-to-back words produce no shift bubble.
    cfg_ready    = (state == LOAD) && (buf_cnt <= BC_W'(1)) && !all_accepted;
    accept       = cfg_valid && cfg_ready;
    last_shift   = shifting && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    // Bits already committed = shifted bits plus the ones still buffered. When
    // a word is accepted at most one buffered bit remains, and it shifts out
    // on the same edge.
    load_len     = clamp_len(CHAIN_LEN - int'(bit_cnt) - int'(buf_cnt));
  end

  assign ccff_shift_en = shifting;
  assign ccff_head     = shifting & shbuf[0];
  assign busy          = (state == LOAD);
  assign done          = (state == DONE);
  assign err_overrun   = err_q;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state          <= IDLE;
      shbuf          <= '0;
      buf_cnt        <= '0;
      bit_cnt        <= '0;
      words_accepted <= '0;
      err_q          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= LOAD;
            shbuf          <= '0;
            buf_cnt        <= '0;
            bit_cnt        <= '0;
            words_accepted <= '0;
            err_q          <= 1'b0;
          end else if (cfg_valid) begin
            // Nobody asked for data yet; the word is refused and flagged.
            err_q <= 1'b1;
          end
        end

        LOAD: begin
          if (abort) begin
            // Chain contents are left partial; nothing shifts on this edge.
            state   <= IDLE;
            buf_cnt <= '0;
          end else begin
            if (cfg_valid && all_accepted) begin
              err_q <= 1'b1;
            end
            if (shifting) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (accept) begin
              shbuf          <= cfg_data;
              buf_cnt        <= load_len;
              words_accepted <= words_accepted + WA_W'(1);
            end else if (shifting) begin
              shbuf   <= shbuf >> 1;
              buf_cnt <= buf_cnt - BC_W'(1);
            end
            if (last_shift) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_chain_loader
//
// Directed bench for ccff_chain_loader with CHAIN_LEN=20, WORD_W=8.
// A cycle-by-cycle vector table covers a full back-to-back load, idle
// overrun, start clearing the error, abort and start/abort priority.
// Hand-written sequences then cover source stalls, abort after 9 bits,
// an extra word after the last one, and reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_ccff_chain_loader;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int NROWS     = 29;

  logic              prog_clk;
  logic              pReset;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              busy;
  logic              done;
  logic              err_overrun;

  ccff_chain_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .abort        (abort),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .busy         (busy),
    .done         (done),
    .err_overrun  (err_overrun)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int checks = 0;
  int errors = 0;

  // Serial stream of A5, 3C and the low nibble of FF, index 0 shifted first.
  logic [19:0] exp_stream;
  logic [7:0]  words [3];

  // exp packs {cfg_ready, ccff_shift_en, ccff_head, busy, done, err_overrun}
  // as seen just after the edge that samples the row's inputs.
  typedef struct {
    logic       start;
    logic       abort;
    logic       valid;
    logic [7:0] data;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [NROWS];

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_row(input int i, input logic s, input logic a, input logic v,
                         input logic [7:0] d, input logic [5:0] e);
    tbl[i].start = s;
    tbl[i].abort = a;
    tbl[i].valid = v;
    tbl[i].data  = d;
    tbl[i].exp   = e;
  endtask

  // Starts a load from IDLE and feeds the three words through the handshake.
  // gap_len : ready-cycles the second word is withheld
  // extra   : offer one more word right after the third is accepted
  // abort_at: abort instead of shifting bit number abort_at (-1 = never)
  task automatic run_load(input int gap_len, input bit extra, input int abort_at,
                          output int done_cyc, output int nshift, output int nstall,
                          output logic [19:0] got, output logic err_done,
                          output logic done_next);
    int   wi;
    int   withheld;
    bit   extra_sent;
    bit   fin;
    bit   saw_done;
    logic acc;
    wi = 0; withheld = 0; extra_sent = 0; fin = 0; saw_done = 0;
    done_cyc = -1; nshift = 0; nstall = 0; got = '0; err_done = 1'b0; done_next = 1'b1;
    start = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        err_done = err_overrun;
        cfg_valid = 1'b0;
        tick();
        done_next = done;
        fin = 1;
      end else if (abort_at >= 0 && nshift == abort_at && ccff_shift_en) begin
        abort = 1'b1;
        cfg_valid = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_to_idle", 32'({busy, ccff_shift_en, done}), 32'd0);
        for (int k = 0; k < 3; k++) begin
          tick();
          if (done) saw_done = 1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);
        done_cyc = -2;
        fin = 1;
      end else begin
        if (ccff_shift_en) begin
          if (nshift < 20) got[nshift] = ccff_head;
          nshift++;
        end else if (busy && nshift > 0) begin
          nstall++;
        end
        if (wi == 1 && withheld < gap_len) begin
          cfg_valid = 1'b0;
          if (cfg_ready) withheld++;
        end else if (wi < 3) begin
          cfg_valid = 1'b1;
          cfg_data  = words[wi];
        end else if (extra && !extra_sent) begin
          cfg_valid  = 1'b1;
          cfg_data   = 8'h77;
          extra_sent = 1;
        end else begin
          cfg_valid = 1'b0;
        end
        acc = cfg_valid && cfg_ready;
        tick();
        if (acc) wi++;
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          done_cyc;
    int          nshift;
    int          nstall;
    logic [19:0] got;
    logic        err_done;
    logic        done_next;

    exp_stream = 20'hF3CA5;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'hFF;

    // Full back-to-back load of A5/3C/FF.
    set_row( 0, 1, 0, 0, 8'h00, 6'b100100);
    set_row( 1, 0, 0, 1, 8'hA5, 6'b011100);
    set_row( 2, 0, 0, 1, 8'h3C, 6'b010100);
    set_row( 3, 0, 0, 1, 8'h3C, 6'b011100);
    set_row( 4, 0, 0, 1, 8'h3C, 6'b010100);
    set_row( 5, 0, 0, 1, 8'h3C, 6'b010100);
    set_row( 6, 0, 0, 1, 8'h3C, 6'b011100);
    set_row( 7, 0, 0, 1, 8'h3C, 6'b010100);
    set_row( 8, 0, 0, 1, 8'h3C, 6'b111100);
    set_row( 9, 0, 0, 1, 8'h3C, 6'b010100);
    set_row(10, 0, 0, 1, 8'hFF, 6'b010100);
    set_row(11, 0, 0, 1, 8'hFF, 6'b011100);
    set_row(12, 0, 0, 1, 8'hFF, 6'b011100);
    set_row(13, 0, 0, 1, 8'hFF, 6'b011100);
    set_row(14, 0, 0, 1, 8'hFF, 6'b011100);
    set_row(15, 0, 0, 1, 8'hFF, 6'b010100);
    set_row(16, 0, 0, 1, 8'hFF, 6'b110100);
    set_row(17, 0, 0, 1, 8'hFF, 6'b011100);
    set_row(18, 0, 0, 0, 8'h00, 6'b011100);
    set_row(19, 0, 0, 0, 8'h00, 6'b011100);
    set_row(20, 0, 0, 0, 8'h00, 6'b011100);
    set_row(21, 0, 0, 0, 8'h00, 6'b000010);
    set_row(22, 0, 0, 0, 8'h00, 6'b000000);
    // Word offered in IDLE: refused and flagged, then cleared by start.
    set_row(23, 0, 0, 1, 8'h55, 6'b000001);
    set_row(24, 0, 0, 0, 8'h00, 6'b000001);
    set_row(25, 1, 0, 0, 8'h00, 6'b100100);
    // Abort of an empty load, then start beating abort in IDLE.
    set_row(26, 0, 1, 0, 8'h00, 6'b000000);
    set_row(27, 1, 1, 0, 8'h00, 6'b100100);
    set_row(28, 0, 1, 0, 8'h00, 6'b000000);

    pReset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    tick();
    tick();
    pReset = 1'b0;
    chk("reset_outputs",
        32'({cfg_ready, ccff_shift_en, ccff_head, busy, done, err_overrun}), 32'd0);

    for (int i = 0; i < NROWS; i++) begin
      start     = tbl[i].start;
      abort     = tbl[i].abort;
      cfg_valid = tbl[i].valid;
      cfg_data  = tbl[i].data;
      tick();
      checks++;
      if ({cfg_ready, ccff_shift_en, ccff_head, busy, done, err_overrun} !== tbl[i].exp) begin
        errors++;
        $display("FAIL row%0d actual=%b required=%b", i,
                 {cfg_ready, ccff_shift_en, ccff_head, busy, done, err_overrun}, tbl[i].exp);
      end
    end
    start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    tick();

    // Back-to-back load through the handshake model.
    run_load(0, 0, -1, done_cyc, nshift, nstall, got, err_done, done_next);
    chk("s1_stream", 32'(got), 32'(exp_stream));
    chk("s1_nshift", 32'(nshift), 32'd20);
    chk("s1_nstall", 32'(nstall), 32'd0);
    chk("s1_done_cyc", 32'(done_cyc), 32'd21);
    chk("s1_done_one_cycle", 32'(done_next), 32'd0);
    chk("s1_err", 32'(err_done), 32'd0);

    // Second word withheld: five stall cycles, done five cycles later.
    run_load(5, 0, -1, done_cyc, nshift, nstall, got, err_done, done_next);
    chk("s2_stream", 32'(got), 32'(exp_stream));
    chk("s2_nstall", 32'(nstall), 32'd5);
    chk("s2_done_cyc", 32'(done_cyc), 32'd26);
    chk("s2_err", 32'(err_done), 32'd0);

    // Abort after nine shifted bits, then a clean reload.
    run_load(0, 0, 9, done_cyc, nshift, nstall, got, err_done, done_next);
    chk("s4_abort_nshift", 32'(nshift), 32'd9);
    chk("s4_abort_path", 32'(done_cyc), 32'hFFFF_FFFE);
    run_load(0, 0, -1, done_cyc, nshift, nstall, got, err_done, done_next);
    chk("s4_reload_stream", 32'(got), 32'(exp_stream));
    chk("s4_reload_done_cyc", 32'(done_cyc), 32'd21);

    // Fourth word after all three accepted: flagged, load not stalled.
    run_load(0, 1, -1, done_cyc, nshift, nstall, got, err_done, done_next);
    chk("s6_err", 32'(err_done), 32'd1);
    chk("s6_done_cyc", 32'(done_cyc), 32'd21);
    chk("s6_stream", 32'(got), 32'(exp_stream));
    chk("s6_err_sticky", 32'(err_overrun), 32'd1);

    // Reset in the middle of a load.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s5_start_clears_err", 32'(err_overrun), 32'd0);
    cfg_valid = 1'b1; cfg_data = 8'hA5;
    tick();
    cfg_data = 8'h3C;
    tick();
    tick();
    chk("s5_pre_reset", 32'({busy, ccff_shift_en}), 32'd3);
    pReset = 1'b1;
    tick();
    chk("s5_reset_outputs",
        32'({cfg_ready, ccff_shift_en, ccff_head, busy, done, err_overrun}), 32'd0);
    pReset = 1'b0;
    cfg_valid = 1'b0;
    tick();
    chk("s5_idle_after_reset",
        32'({cfg_ready, ccff_shift_en, ccff_head, busy, done, err_overrun}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
